// File: rtl/ste_led_bar_enc.sv
// Thermometer encoder: clamps the input magnitude and lights ceil(v*LED_NR/DATA_MAX) LEDs from bit 0.
// Uses a per-LED comparator against a constant threshold instead of a divider.
module ste_led_bar_enc #(
   parameter int unsigned DATA_W   = 3,
   parameter int unsigned DATA_MAX = 7,
   parameter int unsigned LED_NR   = 8
) (
   input  logic [DATA_W-1:0] value,
   output logic [LED_NR-1:0] bar
);

   localparam int unsigned PROD_W = DATA_W + $clog2(LED_NR + 1);
   localparam logic [DATA_W-1:0] MAX_V = DATA_W'(DATA_MAX);

   logic [DATA_W-1:0] clamped;
   logic [PROD_W-1:0] scaled;

   assign clamped = (value > MAX_V) ? MAX_V : value;
   assign scaled  = PROD_W'(clamped) * PROD_W'(LED_NR);

   // LED k lights when v*LED_NR > k*DATA_MAX; thresholds fold to constants
   for (genvar k = 0; k < LED_NR; k++) begin : g_cmp
      localparam int unsigned THR = k * DATA_MAX;
      assign bar[k] = (scaled > PROD_W'(THR));
   end

endmodule

// File: rtl/ste_led_bar.sv
// Bar-graph LED driver: registers the encoded thermometer pattern on each update strobe.
// Clear has priority over update; reset release is synchronised before updates are accepted.
module ste_led_bar #(
   parameter int unsigned DATA_W   = 3,
   parameter int unsigned DATA_MAX = 7,
   parameter int unsigned LED_NR   = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] din_i,
   input  logic              din_update_i,
   input  logic              clr_i,
   output logic [LED_NR-1:0] led_o
);

   // Elaboration-time parameter legality
   if (DATA_W < 1) begin : g_bad_data_w
      $error("ste_led_bar: DATA_W must be >= 1");
   end
   if (DATA_MAX == 0) begin : g_bad_data_max
      $error("ste_led_bar: DATA_MAX must be > 0");
   end
   if (LED_NR < 1) begin : g_bad_led_nr
      $error("ste_led_bar: LED_NR must be >= 1");
   end
   if (DATA_W < 32 && (64'(DATA_MAX) >> DATA_W) != 64'd0) begin : g_bad_fit
      $error("ste_led_bar: DATA_MAX does not fit in DATA_W bits");
   end

   logic [LED_NR-1:0] bar;
   logic [1:0]        rst_sync;
   logic              run;

   ste_led_bar_enc #(
      .DATA_W   (DATA_W),
      .DATA_MAX (DATA_MAX),
      .LED_NR   (LED_NR)
   ) u_enc (
      .value (din_i),
      .bar   (bar)
   );

   // Asynchronous assert, synchronous release of the internal run enable
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign run = rst_sync[1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         led_o <= '0;
      end else if (run) begin
         if (clr_i) begin
            led_o <= '0;
         end else if (din_update_i) begin
            led_o <= bar;
         end
      end
   end

endmodule

// File: tb/tb_ste_led_bar.sv
// Bench for ste_led_bar: vector table, directed corner sequences and random traffic against
// a ceil(v*LED_NR/DATA_MAX) model, on a default instance and a DATA_MAX=5 instance.
module tb_ste_led_bar;

   logic       clk;
   logic       rst_n;
   logic [2:0] din;
   logic       upd;
   logic       clr;
   logic [7:0] led7;
   logic [7:0] led5;

   int pass_cnt = 0;
   int total_cnt = 0;

   ste_led_bar u_dut7 (
      .clk          (clk),
      .rst_n        (rst_n),
      .din_i        (din),
      .din_update_i (upd),
      .clr_i        (clr),
      .led_o        (led7)
   );

   ste_led_bar #(.DATA_W(3), .DATA_MAX(5), .LED_NR(8)) u_dut5 (
      .clk          (clk),
      .rst_n        (rst_n),
      .din_i        (din),
      .din_update_i (upd),
      .clr_i        (clr),
      .led_o        (led5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] din;
      logic [7:0] exp7;
      logic [7:0] exp5;
   } vec_t;

   vec_t vecs[$];

   // Reference: number of lit LEDs is ceil(min(v,max)*8/max), filled from bit 0
   function automatic logic [7:0] ref_bar(input int v, input int max);
      int vc;
      int n;
      logic [8:0] t;
      vc = (v > max) ? max : v;
      n  = (vc * 8 + max - 1) / max;
      t  = (9'd1 << n) - 9'd1;
      return t[7:0];
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      total_cnt++;
      if (act !== exp) begin
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end else begin
         pass_cnt++;
      end
   endtask

   task automatic strobe(input logic [2:0] v);
      @(negedge clk);
      din = v;
      upd = 1'b1;
      @(negedge clk);
      upd = 1'b0;
   endtask

   logic [7:0] m7;
   logic [7:0] m5;

   initial begin
      rst_n = 1'b0;
      din   = 3'd7;
      upd   = 1'b1;
      clr   = 1'b0;

      // Reset held with a strobe pending
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("reset_hold7", led7, 8'h00);
         check("reset_hold5", led5, 8'h00);
      end
      upd   = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("post_reset7", led7, 8'h00);
      end

      // Fill sweep and clamp table
      vecs.push_back('{3'd0, 8'b00000000, 8'b00000000});
      vecs.push_back('{3'd1, 8'b00000011, 8'b00000011});
      vecs.push_back('{3'd2, 8'b00000111, 8'b00001111});
      vecs.push_back('{3'd3, 8'b00001111, 8'b00011111});
      vecs.push_back('{3'd5, 8'b00111111, 8'b11111111});
      vecs.push_back('{3'd7, 8'b11111111, 8'b11111111});
      vecs.push_back('{3'd6, 8'b01111111, 8'b11111111});
      vecs.push_back('{3'd4, 8'b00011111, 8'b01111111});
      foreach (vecs[i]) begin
         strobe(vecs[i].din);
         check($sformatf("sweep7_din%0d", vecs[i].din), led7, vecs[i].exp7);
         check($sformatf("sweep5_din%0d", vecs[i].din), led5, vecs[i].exp5);
      end

      // Hold without strobe
      strobe(3'd7);
      din = 3'd1;
      repeat (2) @(negedge clk);
      check("hold7", led7, 8'hFF);
      check("hold5", led5, 8'hFF);

      // Clear pulse
      clr = 1'b1;
      @(negedge clk);
      clr = 1'b0;
      check("clear7", led7, 8'h00);
      check("clear5", led5, 8'h00);

      // Clear beats simultaneous update
      strobe(3'd3);
      din = 3'd7;
      upd = 1'b1;
      clr = 1'b1;
      @(negedge clk);
      upd = 1'b0;
      clr = 1'b0;
      check("clr_wins7", led7, 8'h00);
      check("clr_wins5", led5, 8'h00);

      // Asynchronous reset mid-cycle with an update in flight
      strobe(3'd3);
      check("preload7", led7, 8'b00001111);
      din = 3'd5;
      upd = 1'b1;
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst7", led7, 8'h00);
      check("async_rst5", led5, 8'h00);
      @(negedge clk);
      upd   = 1'b0;
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("after_rst7", led7, 8'h00);

      // Random traffic against the model
      m7 = 8'h00;
      m5 = 8'h00;
      for (int i = 0; i < 300; i++) begin
         din = 3'($urandom_range(0, 7));
         upd = 1'($urandom_range(0, 1));
         clr = ($urandom_range(0, 9) == 0);
         @(negedge clk);
         if (clr) begin
            m7 = 8'h00;
            m5 = 8'h00;
         end else if (upd) begin
            m7 = ref_bar(int'(din), 7);
            m5 = ref_bar(int'(din), 5);
         end
         check($sformatf("rand7_%0d", i), led7, m7);
         check($sformatf("rand5_%0d", i), led5, m5);
      end
      upd = 1'b0;
      clr = 1'b0;

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
